// File: rtl/xprs_pkg.sv
// Shared widths, FSM encoding and source IDs for the xprs write-port arbiter.
package xprs_pkg;

    localparam int XLEN       = 64;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The priority flop names the side that wins a
// conflict and flips to the other side after every grant. It holds while
// nothing is granted.
module rr_arb2
    import xprs_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic pri_q;
    logic pri_d;

    // Pick a winner from the requests and compute the rotated priority
    always_comb begin
        gnt_o = 2'b00;
        pri_d = pri_q;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = (pri_q == SRC_A) ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
        if (gnt_o[SRC_A]) begin
            pri_d = SRC_B;
        end else if (gnt_o[SRC_B]) begin
            pri_d = SRC_A;
        end
    end

    // Priority register, favours A out of reset
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pri_q <= SRC_A;
        end else begin
            pri_q <= pri_d;
        end
    end

endmodule

// File: rtl/xprs_wport_arb.sv
// Owner of the xprs write port. Out of reset it clears x1..x(NREGS-1) one
// register per cycle, then shares the port between the ALU writeback (A) and
// the load writeback (B) with round-robin arbitration and zero added latency.
//
//  state | meaning
//  CLEAR | writing 0 to register cnt, sources are held off
//  RUN   | port granted to A or B from valids, stall and priority
module xprs_wport_arb #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            stall_i,
    input  logic            a_valid_i,
    input  logic [4:0]      a_rd_i,
    input  logic [XLEN-1:0] a_d_i,
    output logic            a_ready_o,
    input  logic            b_valid_i,
    input  logic [4:0]      b_rd_i,
    input  logic [XLEN-1:0] b_d_i,
    output logic            b_ready_o,
    output logic            we_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] d_o,
    output logic            init_done_o
);

    import xprs_pkg::*;

    localparam logic [REG_ADDR_W-1:0] LAST_REG = REG_ADDR_W'(NREGS - 1);

    state_e                state_q;
    state_e                state_d;
    logic [REG_ADDR_W-1:0] cnt_q;
    logic [REG_ADDR_W-1:0] cnt_d;
    logic                  init_done_q;
    logic                  init_done_d;
    logic                  arb_en;
    logic [1:0]            gnt;

    assign arb_en = (state_q == RUN) && !stall_i;

    rr_arb2 u_arb (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .req_i   ({b_valid_i, a_valid_i}),
        .en_i    (arb_en),
        .gnt_o   (gnt)
    );

    // Clear-pass sequencing: advance cnt and leave CLEAR after the last register
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_REG) begin
                state_d     = RUN;
                init_done_d = 1'b1;
            end
        end
    end

    // State, clear counter and done flag
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= CLEAR;
            cnt_q       <= REG_ADDR_W'(1);
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    // Write-port mux; reset is folded in so the port is quiet while reset is held
    always_comb begin
        we_o      = 1'b0;
        rd_o      = '0;
        d_o       = '0;
        a_ready_o = 1'b0;
        b_ready_o = 1'b0;
        if (!reset_i) begin
            if (state_q == CLEAR) begin
                we_o = 1'b1;
                rd_o = cnt_q;
            end else if (gnt[SRC_A]) begin
                a_ready_o = 1'b1;
                we_o      = (a_rd_i != 5'd0);
                rd_o      = a_rd_i;
                d_o       = a_d_i;
            end else if (gnt[SRC_B]) begin
                b_ready_o = 1'b1;
                we_o      = (b_rd_i != 5'd0);
                rd_o      = b_rd_i;
                d_o       = b_d_i;
            end
        end
    end

    assign init_done_o = init_done_q;

endmodule

// File: tb/tb_xprs_wport_arb.sv
// Bench for xprs_wport_arb: a register-file model captures the write port,
// and a reference model of the arbitration rules predicts every cycle.
module tb_xprs_wport_arb;

    logic        clk_i     = 1'b0;
    logic        reset_i   = 1'b1;
    logic        stall_i   = 1'b0;
    logic        a_valid_i = 1'b0;
    logic [4:0]  a_rd_i    = 5'd0;
    logic [63:0] a_d_i     = 64'd0;
    logic        b_valid_i = 1'b0;
    logic [4:0]  b_rd_i    = 5'd0;
    logic [63:0] b_d_i     = 64'd0;
    logic        a_ready_o;
    logic        b_ready_o;
    logic        we_o;
    logic [4:0]  rd_o;
    logic [63:0] d_o;
    logic        init_done_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] rf     [32];
    logic [63:0] exp_rf [32];
    logic        prefill = 1'b1;
    int          pri_m   = 0;

    xprs_wport_arb #(.XLEN(64), .NREGS(32)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .stall_i     (stall_i),
        .a_valid_i   (a_valid_i),
        .a_rd_i      (a_rd_i),
        .a_d_i       (a_d_i),
        .a_ready_o   (a_ready_o),
        .b_valid_i   (b_valid_i),
        .b_rd_i      (b_rd_i),
        .b_d_i       (b_d_i),
        .b_ready_o   (b_ready_o),
        .we_o        (we_o),
        .rd_o        (rd_o),
        .d_o         (d_o),
        .init_done_o (init_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Register file stand-in; stores even x0 so a stray x0 write is visible
    always @(posedge clk_i) begin
        if (prefill) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= (i == 0) ? 64'd0 : (64'hA5A5_0000_0000_0000 | 64'(i));
            end
        end else if (we_o) begin
            rf[rd_o] <= d_o;
        end
    end

    // -1 no grant, 0 A, 1 B
    function automatic int model_grant();
        if (stall_i) return -1;
        if (a_valid_i && b_valid_i) return pri_m;
        if (a_valid_i) return 0;
        if (b_valid_i) return 1;
        return -1;
    endfunction

    // Expected {a_ready, b_ready, we, rd, d}
    function automatic logic [71:0] model_vec(int g);
        logic [4:0]  r;
        logic [63:0] d;
        if (g < 0) return 72'd0;
        r = (g == 0) ? a_rd_i : b_rd_i;
        d = (g == 0) ? a_d_i : b_d_i;
        return {g == 0, g == 1, r != 5'd0, r, d};
    endfunction

    function automatic logic [71:0] model_mask();
        if (stall_i) return {3'b111, 69'd0};
        return {72{1'b1}};
    endfunction

    task automatic model_commit(int g);
        logic [4:0]  r;
        if (g >= 0) begin
            r = (g == 0) ? a_rd_i : b_rd_i;
            if (r != 5'd0) exp_rf[r] = (g == 0) ? a_d_i : b_d_i;
            pri_m = 1 - g;
        end
    endtask

    task automatic test_reset();
        logic [71:0] got;
        #1;
        got = {a_ready_o, b_ready_o, we_o, rd_o, d_o};
        n_checks++;
        if (got !== 72'd0 || init_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h done %b, expected 0 done 0", got, init_done_o);
        end
        a_valid_i = 1'b1; a_rd_i = 5'd3; a_d_i = 64'h0333_0000_0000_0003;
        b_valid_i = 1'b1; b_rd_i = 5'd4; b_d_i = 64'h0444_0000_0000_0004;
        stall_i   = 1'b1;
        @(posedge clk_i); #1;
        prefill = 1'b0;
        for (int i = 0; i < 32; i++) exp_rf[i] = (i == 0) ? 64'd0 : (64'hA5A5_0000_0000_0000 | 64'(i));
        @(negedge clk_i);
        got = {a_ready_o, b_ready_o, we_o, rd_o, d_o};
        n_checks++;
        if (got !== 72'd0 || init_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held_valids: got %h done %b, expected 0 done 0", got, init_done_o);
        end
    endtask

    // Releases reset at a negedge and checks the whole clear pass
    task automatic run_clear(string name);
        logic [72:0] got;
        logic [72:0] ev;
        @(negedge clk_i);
        reset_i = 1'b0;
        pri_m   = 0;
        #1;
        for (int k = 1; k <= 31; k++) begin
            got = {a_ready_o, b_ready_o, we_o, rd_o, d_o, init_done_o};
            ev  = {3'b001, 5'(k), 64'd0, 1'b0};
            n_checks++;
            if (got !== ev) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, k, got, ev);
            end
            @(posedge clk_i); #1;
        end
        for (int i = 1; i < 32; i++) exp_rf[i] = 64'd0;
        n_checks++;
        if (init_done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s init_done: got %b expected 1", name, init_done_o);
        end
    endtask

    task automatic test_clear();
        logic [71:0] got;
        logic [71:0] ev;
        int g;
        stall_i = 1'b0;
        run_clear("clear_pass");
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (rf[i] !== exp_rf[i]) begin
                n_fail++;
                $display("FAIL clear_rf x%0d: got %h expected %h", i, rf[i], exp_rf[i]);
            end
        end
        // requests held through CLEAR are granted A first, then B
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            g   = model_grant();
            ev  = model_vec(g);
            got = {a_ready_o, b_ready_o, we_o, rd_o, d_o};
            n_checks++;
            if (got !== ev || g != c) begin
                n_fail++;
                $display("FAIL clear_pending cycle %0d: got %h expected %h", c, got, ev);
            end
            @(posedge clk_i);
            model_commit(g);
            #1;
            if (g == 0) a_valid_i = 1'b0;
            if (g == 1) b_valid_i = 1'b0;
        end
    endtask

    task automatic test_a_only();
        logic [71:0] got;
        logic [71:0] ev;
        int g;
        a_valid_i = 1'b1; a_rd_i = 5'd5; a_d_i = 64'hDEADBEEFFEEDFACE;
        b_valid_i = 1'b0;
        @(negedge clk_i);
        g   = model_grant();
        ev  = model_vec(g);
        got = {a_ready_o, b_ready_o, we_o, rd_o, d_o};
        n_checks++;
        if (got !== ev) begin
            n_fail++;
            $display("FAIL a_only: got %h expected %h", got, ev);
        end
        @(posedge clk_i);
        model_commit(g);
        #1;
        a_valid_i = 1'b0;
        n_checks++;
        if (rf[5] !== 64'hDEADBEEFFEEDFACE) begin
            n_fail++;
            $display("FAIL a_only_x5: got %h expected deadbeeffeedface", rf[5]);
        end
    endtask

    task automatic test_back_to_back();
        logic [71:0] got;
        logic [71:0] ev;
        int g;
        int wait_a = 0;
        int wait_b = 0;
        a_valid_i = 1'b1; a_rd_i = 5'd7; a_d_i = {$urandom, $urandom};
        b_valid_i = 1'b1; b_rd_i = 5'd8; b_d_i = {$urandom, $urandom};
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            g   = model_grant();
            ev  = model_vec(g);
            got = {a_ready_o, b_ready_o, we_o, rd_o, d_o};
            n_checks++;
            if (got !== ev) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", c, got, ev);
            end
            if (a_ready_o) wait_a = 0; else wait_a++;
            if (b_ready_o) wait_b = 0; else wait_b++;
            n_checks++;
            if (wait_a > 1 || wait_b > 1) begin
                n_fail++;
                $display("FAIL back_to_back_wait cycle %0d: waits A %0d B %0d, limit 1", c, wait_a, wait_b);
            end
            @(posedge clk_i);
            model_commit(g);
            #1;
            if (g == 0) a_d_i = {$urandom, $urandom};
            if (g == 1) b_d_i = {$urandom, $urandom};
        end
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        n_checks++;
        if (rf[7] !== exp_rf[7] || rf[8] !== exp_rf[8]) begin
            n_fail++;
            $display("FAIL back_to_back_rf: got %h %h expected %h %h", rf[7], rf[8], exp_rf[7], exp_rf[8]);
        end
    endtask

    task automatic test_rd0();
        logic [71:0] got;
        int g;
        b_valid_i = 1'b1; b_rd_i = 5'd0; b_d_i = 64'h1111111111111111;
        @(negedge clk_i);
        g   = model_grant();
        got = {a_ready_o, b_ready_o, we_o, rd_o, d_o};
        n_checks++;
        if (got !== {3'b010, 5'd0, 64'h1111111111111111}) begin
            n_fail++;
            $display("FAIL rd0_handshake: got %h expected 010 rd 0 d 1111111111111111", got);
        end
        @(posedge clk_i);
        model_commit(g);
        #1;
        b_valid_i = 1'b0;
        n_checks++;
        if (rf[0] !== 64'd0) begin
            n_fail++;
            $display("FAIL rd0_x0: got %h expected 0", rf[0]);
        end
        a_valid_i = 1'b1; a_rd_i = 5'd9;  a_d_i = 64'h0999_0000_0000_0009;
        b_valid_i = 1'b1; b_rd_i = 5'd10; b_d_i = 64'h0AAA_0000_0000_000A;
        @(negedge clk_i);
        g = model_grant();
        n_checks++;
        if (a_ready_o !== 1'b1 || b_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rd0_pri_rotate: got readys a %b b %b expected a 1 b 0", a_ready_o, b_ready_o);
        end
        @(posedge clk_i);
        model_commit(g);
        #1;
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
    endtask

    task automatic test_stall();
        logic [71:0] got;
        logic [71:0] ev;
        int g;
        int pri_before;
        // after test_rd0 pri names B; make a conflict flip it to exercise B first
        a_valid_i = 1'b1; a_rd_i = 5'd11; a_d_i = {$urandom, $urandom};
        b_valid_i = 1'b1; b_rd_i = 5'd12; b_d_i = {$urandom, $urandom};
        stall_i   = 1'b1;
        pri_before = pri_m;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            g   = model_grant();
            ev  = model_vec(g);
            got = {a_ready_o, b_ready_o, we_o, rd_o, d_o};
            n_checks++;
            if (((got ^ ev) & model_mask()) !== 72'd0) begin
                n_fail++;
                $display("FAIL stall cycle %0d: got %h expected readys/we 0", c, got);
            end
            @(posedge clk_i);
            model_commit(g);
            #1;
        end
        stall_i = 1'b0;
        @(negedge clk_i);
        g = model_grant();
        n_checks++;
        if ({a_ready_o, b_ready_o} !== ((pri_before == 0) ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL stall_release: got readys %b%b expected side %0d", a_ready_o, b_ready_o, pri_before);
        end
        @(posedge clk_i);
        model_commit(g);
        #1;
        if (g == 0) a_valid_i = 1'b0;
        if (g == 1) b_valid_i = 1'b0;
    endtask

    task automatic test_random();
        logic [71:0] got;
        logic [71:0] ev;
        int g;
        int errs = 0;
        for (int c = 0; c < 400; c++) begin
            if (!a_valid_i && ($urandom % 3) != 0) begin
                a_valid_i = 1'b1; a_rd_i = 5'($urandom); a_d_i = {$urandom, $urandom};
            end
            if (!b_valid_i && ($urandom % 3) != 0) begin
                b_valid_i = 1'b1; b_rd_i = 5'($urandom); b_d_i = {$urandom, $urandom};
            end
            stall_i = (($urandom % 5) == 0);
            @(negedge clk_i);
            g   = model_grant();
            ev  = model_vec(g);
            got = {a_ready_o, b_ready_o, we_o, rd_o, d_o};
            n_checks++;
            if (((got ^ ev) & model_mask()) !== 72'd0) begin
                n_fail++;
                if (errs < 10) $display("FAIL random cycle %0d: got %h expected %h", c, got, ev);
                errs++;
            end
            @(posedge clk_i);
            model_commit(g);
            #1;
            if (g == 0) a_valid_i = 1'b0;
            if (g == 1) b_valid_i = 1'b0;
        end
        stall_i   = 1'b0;
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (rf[i] !== exp_rf[i]) begin
                n_fail++;
                $display("FAIL random_rf x%0d: got %h expected %h", i, rf[i], exp_rf[i]);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [72:0] got;
        @(negedge clk_i);
        reset_i = 1'b1;
        #1;
        got = {a_ready_o, b_ready_o, we_o, rd_o, d_o, init_done_o};
        n_checks++;
        if (got !== 73'd0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got %h expected 0", got);
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        for (int k = 1; k <= 10; k++) begin
            n_checks++;
            if ({we_o, rd_o} !== {1'b1, 5'(k)}) begin
                n_fail++;
                $display("FAIL reset_mid_clear_pre cycle %0d: got we %b rd %0d expected we 1 rd %0d", k, we_o, rd_o, k);
            end
            @(posedge clk_i); #1;
        end
        #1;
        reset_i = 1'b1;
        #1;
        got = {a_ready_o, b_ready_o, we_o, rd_o, d_o, init_done_o};
        n_checks++;
        if (got !== 73'd0) begin
            n_fail++;
            $display("FAIL reset_mid_clear_async: got %h expected 0", got);
        end
        run_clear("reclear_pass");
        a_valid_i = 1'b1; a_rd_i = 5'd13; a_d_i = 64'h0D0D;
        b_valid_i = 1'b1; b_rd_i = 5'd14; b_d_i = 64'h0E0E;
        @(negedge clk_i);
        n_checks++;
        if ({a_ready_o, b_ready_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL reclear_pri_a: got readys %b%b expected 10", a_ready_o, b_ready_o);
        end
        @(posedge clk_i); #1;
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clear();
        test_a_only();
        test_back_to_back();
        test_rd0();
        test_stall();
        test_random();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
